seg7_encoder: RTL and testbench

SEG7_ENCODER -- requirements
Module: seg7_encoder

---
 rtl/seg7_encoder.sv | 130 +++++++++++++
 tb/tb_seg7_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_encoder.sv
// seg7_encoder
// Converts an asynchronous, active-low 7-segment bus into decoded digits.
// The bus is synchronized, debounced by a stability filter, checked against
// the last accepted pattern, and the result is offered on a valid/ready slot.
//
// Ports
//   clk        : single clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   seg_n      : active-low segment bus, bit0=a .. bit6=g (async to clk)
//   out_ready  : consumer takes the held result this cycle when high
//   out_valid  : out_digit/out_err hold an unaccepted result
//   out_digit  : decoded digit 0-9, 4'hF for an illegal pattern
//   out_err    : reported pattern is not a legal digit
//   ovf        : one-cycle pulse when a result is dropped (slot full, not ready)
module seg7_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       ovf
);

  localparam logic [6:0] BLANK     = 7'h7F;
  localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  // Returns {err, digit}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b0, 4'd0};
      7'h79:   decode = {1'b0, 4'd1};
      7'h24:   decode = {1'b0, 4'd2};
      7'h30:   decode = {1'b0, 4'd3};
      7'h19:   decode = {1'b0, 4'd4};
      7'h12:   decode = {1'b0, 4'd5};
      7'h02:   decode = {1'b0, 4'd6};
      7'h78:   decode = {1'b0, 4'd7};
      7'h00:   decode = {1'b0, 4'd8};
      7'h10:   decode = {1'b0, 4'd9};
      default: decode = {1'b1, 4'hF};
    endcase
  endfunction

  logic [6:0] s1_q, s1_d, s2_q, s2_d;
  logic [6:0] cand_q, cand_d, last_rep_q, last_rep_d;
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d, err_q, err_d, ovf_q, ovf_d;
  logic [3:0] digit_q, digit_d;

  logic       stable, accept, report, xfer;
  logic [4:0] dec;

  always_comb begin
    // Synchronizer stage
    s1_d = seg_n;
    s2_d = s1_q;

    // Stability filter stage: cnt saturates at STABLE_CYCLES, so the accept
    // event (cnt crossing STABLE_CYCLES-1) fires once per stable run.
    stable = (s2_q == cand_q);
    accept = stable && (cnt_q == STABLE_M1);
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (!stable) begin
      cand_d = s2_q;
      cnt_d  = 8'd1;
    end else if (cnt_q < STABLE_C) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Report stage: blanks are remembered but never reported, so a digit
    // repeated after a blank is reported again.
    last_rep_d = accept ? cand_q : last_rep_q;
    report     = accept && (cand_q != last_rep_q) && (cand_q != BLANK);
    dec        = decode(cand_q);

    // Output slot stage
    xfer    = valid_q && out_ready;
    valid_d = valid_q;
    digit_d = digit_q;
    err_d   = err_q;
    ovf_d   = 1'b0;
    if (report) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        digit_d = dec[3:0];
        err_d   = dec[4];
      end else begin
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= BLANK;
      s2_q       <= BLANK;
      cand_q     <= BLANK;
      last_rep_q <= BLANK;
      cnt_q      <= STABLE_C;
      valid_q    <= 1'b0;
      digit_q    <= 4'd0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cand_q     <= cand_d;
      last_rep_q <= last_rep_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      digit_q    <= digit_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_digit = digit_q;
  assign out_err   = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_encoder.sv
module tb_seg7_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_n = 7'h7F;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  // Report tracking filled by run()
  int nrep, novf, nchg;
  logic [3:0] last_digit;

  seg7_encoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .out_ready(out_ready),
    .out_valid(out_valid), .out_digit(out_digit), .out_err(out_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       exp_valid;
    logic [3:0] exp_digit;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, drive pattern, release just after an edge; the next rising
  // edge is the first one that samples seg_n.
  task automatic do_reset(input logic [6:0] pat);
    rst_n = 1'b0;
    seg_n = pat;
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_digit", 32'(out_digit), 0);
    check("rst_err",   32'(out_err), 0);
    check("rst_ovf",   32'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clr_stats();
    nrep = 0; novf = 0; nchg = 0; last_digit = 4'd0;
  endtask

  // Hold a pattern for n cycles, counting reports (valid samples while
  // ready=1 are one-cycle pulses), ovf pulses, and output changes while held.
  task automatic run(input logic [6:0] pat, input int n);
    logic [3:0] prev_d;
    logic       prev_v;
    seg_n = pat;
    for (int i = 0; i < n; i++) begin
      prev_d = out_digit;
      prev_v = out_valid;
      tick();
      if (out_valid && (out_ready || !prev_v)) begin
        nrep++;
        last_digit = out_digit;
      end
      if (ovf) novf++;
      if (prev_v && out_valid && !out_ready && out_digit != prev_d) nchg++;
    end
  endtask

  initial begin
    vecs[0]  = '{7'h40, 1'b1, 4'd0, 1'b0};
    vecs[1]  = '{7'h79, 1'b1, 4'd1, 1'b0};
    vecs[2]  = '{7'h24, 1'b1, 4'd2, 1'b0};
    vecs[3]  = '{7'h30, 1'b1, 4'd3, 1'b0};
    vecs[4]  = '{7'h19, 1'b1, 4'd4, 1'b0};
    vecs[5]  = '{7'h12, 1'b1, 4'd5, 1'b0};
    vecs[6]  = '{7'h02, 1'b1, 4'd6, 1'b0};
    vecs[7]  = '{7'h78, 1'b1, 4'd7, 1'b0};
    vecs[8]  = '{7'h00, 1'b1, 4'd8, 1'b0};
    vecs[9]  = '{7'h10, 1'b1, 4'd9, 1'b0};
    vecs[10] = '{7'h7E, 1'b1, 4'hF, 1'b1};
    vecs[11] = '{7'h7F, 1'b0, 4'd0, 1'b0};

    // Single pattern held across reset release, out_ready=1: valid appears
    // after edge 6 for exactly one cycle.
    out_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      do_reset(vecs[v].seg);
      repeat (5) tick();
      check($sformatf("v%0d_early", v), 32'(out_valid), 0);
      tick();
      check($sformatf("v%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d_digit", v), 32'(out_digit), 32'(vecs[v].exp_digit));
      check($sformatf("v%0d_err", v),   32'(out_err),   32'(vecs[v].exp_err));
      tick();
      check($sformatf("v%0d_pulse", v), 32'(out_valid), 0);
      clr_stats();
      run(vecs[v].seg, 10);
      check($sformatf("v%0d_norepeat", v), 32'(nrep), 0);
    end

    // Short glitch to 2 between stable 1s: one report, digit 1.
    do_reset(7'h79);
    clr_stats();
    run(7'h79, 10);
    run(7'h24, 2);
    run(7'h79, 15);
    check("glitch_nrep", 32'(nrep), 1);
    check("glitch_digit", 32'(last_digit), 1);

    // Blank between identical digits: two reports of 5.
    do_reset(7'h12);
    clr_stats();
    run(7'h12, 10);
    run(7'h7F, 10);
    check("blank_nrep1", 32'(nrep), 1);
    run(7'h12, 10);
    check("blank_nrep2", 32'(nrep), 2);
    check("blank_digit", 32'(last_digit), 5);

    // Full slot, consumer stalled: second result is dropped with one ovf.
    out_ready = 1'b0;
    do_reset(7'h02);
    clr_stats();
    run(7'h02, 10);
    run(7'h00, 10);
    check("ovf_count", 32'(novf), 1);
    check("ovf_valid", 32'(out_valid), 1);
    check("ovf_digit", 32'(out_digit), 6);
    check("ovf_hold",  32'(nchg), 0);
    out_ready = 1'b1;
    tick();
    check("ovf_xfer", 32'(out_valid), 0);

    // Ready while empty has no effect.
    run(7'h00, 5);
    check("ready_empty", 32'(out_valid), 0);

    // Asynchronous reset mid-cycle while a result is pending.
    out_ready = 1'b0;
    do_reset(7'h30);
    run(7'h30, 10);
    check("arst_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_digit", 32'(out_digit), 0);
    check("arst_err",   32'(out_err), 0);
    check("arst_ovf",   32'(ovf), 0);
    seg_n = 7'h7F;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_stats();
    run(7'h7F, 15);
    check("arst_blank_nrep", 32'(nrep), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
